muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the execute stage.
- Captures operands when the main decoder flags an M-extension instruction (opcode 0110011, funct7 = 0000001).
- Runs a radix-2 shift-add / restoring-divide loop over XLEN cycles, holding the core via a stall output.
- Returns the result on a one-cycle done pulse so the core writes it back and advances the PC.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/muldiv_step.sv | 38 +++
 rtl/muldiv_sequencer.sv | 135 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants and state type for the RV32M multiply/divide sequencer
package muldiv_pkg;

   localparam int DEF_XLEN = 32;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring shift-subtract divide
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic                is_div_i,
   input  logic [2*XLEN-1:0]   acc_i,
   input  logic [XLEN-1:0]     opnd_i,
   output logic [2*XLEN-1:0]   acc_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // Multiply: acc = {partial product high, remaining multiplier bits}.
   // Divide:   acc = {partial remainder, dividend bits becoming quotient bits}.
   assign sum     = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, opnd_i};
   assign shifted = acc_i[2*XLEN-1:XLEN-1];
   assign diff    = shifted - {1'b0, opnd_i};

   always_comb begin
      acc_o = acc_i;
      if (is_div_i) begin
         if (diff[XLEN]) begin
            acc_o = {shifted[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
         end else begin
            acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
         end
      end else if (acc_i[0]) begin
         acc_o = {sum, acc_i[XLEN-1:1]};
      end else begin
         acc_o = {1'b0, acc_i[2*XLEN-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide unit with core stall and done pulse
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   input  logic              flush,
   output logic              busy,
   output logic              stall,
   output logic              done,
   output logic [XLEN-1:0]   result
);

   state_e              state_q;
   logic [2:0]          f3_q;
   logic                neg_q;
   logic [XLEN-1:0]     opnd_q;
   logic [2*XLEN-1:0]   acc_q;
   logic [2*XLEN-1:0]   acc_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [XLEN-1:0]     result_q;
   logic                done_q;
   logic                busy_q;

   logic                a_signed, b_signed, sa, sb;
   logic [XLEN-1:0]     a_mag, b_mag;
   logic                cap_neg, div_zero, div_ovf;
   logic [2*XLEN-1:0]   mul_full;
   logic [XLEN-1:0]     mul_res, div_word, div_res, fix_res;

   assign a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                     (funct3 == F3_DIV)  || (funct3 == F3_REM);
   assign b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
   assign sa       = a_signed & op_a[XLEN-1];
   assign sb       = b_signed & op_b[XLEN-1];
   assign a_mag    = sa ? -op_a : op_a;
   assign b_mag    = sb ? -op_b : op_b;
   // Remainder takes the dividend's sign; product and quotient take sa^sb.
   assign cap_neg  = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
   assign div_zero = funct3[2] && (op_b == '0);
   assign div_ovf  = funct3[2] && !funct3[0] && (op_b == '1) &&
                     (op_a == {1'b1, {(XLEN-1){1'b0}}});

   muldiv_step #(.XLEN(XLEN)) u_step (
      .is_div_i (f3_q[2]),
      .acc_i    (acc_q),
      .opnd_i   (opnd_q),
      .acc_o    (acc_d)
   );

   assign mul_full = neg_q ? -acc_q : acc_q;
   assign mul_res  = (f3_q[1:0] == 2'b00) ? mul_full[XLEN-1:0] : mul_full[2*XLEN-1:XLEN];
   assign div_word = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
   assign div_res  = neg_q ? -div_word : div_word;
   assign fix_res  = f3_q[2] ? div_res : mul_res;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         f3_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start && !flush) begin
                  f3_q   <= funct3;
                  cnt_q  <= '0;
                  busy_q <= 1'b1;
                  // Special cases are preloaded so FIX selects them with no sign fix-up.
                  if (div_zero) begin
                     acc_q   <= {op_a, {XLEN{1'b1}}};
                     neg_q   <= 1'b0;
                     state_q <= FIX;
                  end else if (div_ovf) begin
                     acc_q   <= {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
                     neg_q   <= 1'b0;
                     state_q <= FIX;
                  end else begin
                     acc_q   <= {{XLEN{1'b0}}, a_mag};
                     opnd_q  <= b_mag;
                     neg_q   <= cap_neg;
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(XLEN-1)) begin
                     state_q <= FIX;
                  end
               end
            end
            FIX: begin
               if (flush) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  result_q <= fix_res;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign stall  = ((state_q == IDLE) && start && !flush) || (state_q == CALC) || (state_q == FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int XLEN = DEF_XLEN;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic            flush = 1'b0;
   logic [2:0]      funct3 = '0;
   logic [XLEN-1:0] op_a = '0;
   logic [XLEN-1:0] op_b = '0;
   logic            busy, stall, done;
   logic [XLEN-1:0] result;

   int              checks = 0;
   int              errors = 0;
   logic [XLEN-1:0] exp_q[$];
   logic [XLEN-1:0] prev;

   always #5 clk = ~clk;

   muldiv_sequencer dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .funct3 (funct3),
      .op_a   (op_a),
      .op_b   (op_b),
      .flush  (flush),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic watch_no_done(input string tag, input int n);
      int d;
      d = 0;
      repeat (n) begin
         @(negedge clk);
         if (done) d++;
      end
      check(tag, 64'(d), 64'd0);
   endtask

   task automatic run_op(input string tag, input logic [2:0] f3, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp,
                         input int lat, input bit hold);
      int              cyc;
      int              stall_cnt;
      logic [XLEN-1:0] want;
      cyc = 0;
      stall_cnt = 0;
      @(negedge clk);
      funct3 = f3;
      op_a   = a;
      op_b   = b;
      start  = 1'b1;
      exp_q.push_back(exp);
      #1;
      if (stall) stall_cnt++;
      while (cyc < 100) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (done) break;
         if (stall) stall_cnt++;
         if (!hold) start = 1'b0;
         op_a   = $urandom;
         op_b   = $urandom;
         funct3 = 3'($urandom);
      end
      check({tag, " done"}, 64'(done), 64'd1);
      check({tag, " latency"}, 64'(cyc), 64'(lat));
      check({tag, " stall_cycles"}, 64'(stall_cnt), 64'(lat));
      check({tag, " stall_on_done"}, 64'(stall), 64'd0);
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check({tag, " result"}, 64'(result), 64'(want));
      @(posedge clk);
      @(negedge clk);
      check({tag, " done_one_cycle"}, 64'(done), 64'd0);
      start = 1'b0;
      if (hold) begin
         watch_no_done({tag, " start_in_done_ignored"}, 40);
         check({tag, " idle_after_hold"}, 64'(busy), 64'd0);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset done", 64'(done), 64'd0);
      check("reset result", 64'(result), 64'd0);
      check("reset stall", 64'(stall), 64'd0);
      rst_n = 1'b1;

      run_op("mul",    F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b0);
      run_op("mulhu",  F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
      run_op("mulh",   F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 34, 1'b0);
      run_op("mulhsu", F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34, 1'b0);
      run_op("div",    F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34, 1'b0);
      run_op("rem",    F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34, 1'b0);
      run_op("divu",   F3_DIVU,   32'd100,        32'd7,         32'd14,        34, 1'b1);
      run_op("remu",   F3_REMU,   32'd100,        32'd7,         32'd2,         34, 1'b0);
      run_op("divu0",  F3_DIVU,   32'd123,        32'd0,         32'hFFFF_FFFF, 2,  1'b0);
      run_op("rem0",   F3_REM,    32'd5,          32'd0,         32'd5,         2,  1'b0);
      run_op("divovf", F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,  1'b0);
      run_op("removf", F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2,  1'b0);

      prev = result;
      @(negedge clk);
      funct3 = F3_DIV;
      op_a   = 32'd1000;
      op_b   = 32'd3;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      check("flush done", 64'(done), 64'd0);
      check("flush stall", 64'(stall), 64'd0);
      check("flush result", 64'(result), 64'(prev));
      watch_no_done("flush no_done", 40);

      run_op("mul_after_flush", F3_MUL, 32'd3, 32'd4, 32'd12, 34, 1'b0);

      @(negedge clk);
      funct3 = F3_MULHU;
      op_a   = 32'h0000_FFFF;
      op_b   = 32'h0000_FFFF;
      start  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("async_reset busy", 64'(busy), 64'd0);
      check("async_reset done", 64'(done), 64'd0);
      check("async_reset result", 64'(result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      watch_no_done("async_reset no_done", 40);

      @(negedge clk);
      funct3 = F3_MUL;
      op_a   = 32'd2;
      op_b   = 32'd3;
      start  = 1'b1;
      flush  = 1'b1;
      #1;
      check("start_flush stall", 64'(stall), 64'd0);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      check("start_flush busy", 64'(busy), 64'd0);
      watch_no_done("start_flush no_done", 40);
      check("start_flush result", 64'(result), 64'd0);

      check("scoreboard empty", 64'(exp_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
